// File: rtl/stream_demux_n.sv
// 1:N stream demultiplexer with packet-locked routing and one output register per channel.
// Optional saturating drop counter enabled by defining STREAM_DEMUX_DROP_CNT_EN.
module stream_demux_n #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 4,
  parameter int SEL_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [N_OUT-1:0]       out_valid,
  output logic [N_OUT-1:0]       out_last,
  input  logic [N_OUT-1:0]       out_ready,
  output logic                   busy
`ifdef STREAM_DEMUX_DROP_CNT_EN
  ,
  output logic [15:0]            drop_cnt
`endif
);

  typedef enum logic {IDLE, LOCKED} state_e;

  localparam int SEL_N = 2**SEL_W;

  state_e           state_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] eff;
  logic             accept;
  // Indexed by every select code; codes past N_OUT always accept (and drop).
  logic [SEL_N-1:0] can_load;

  assign eff      = (state_q == LOCKED) ? sel_q : in_sel;
  assign in_ready = can_load[eff];
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q == LOCKED);

  for (genvar k = 0; k < SEL_N; k++) begin : g_ch
    if (k < N_OUT) begin : g_real
      logic             v_q;
      logic             l_q;
      logic [WIDTH-1:0] d_q;
      logic             load;

      assign load        = accept && (eff == SEL_W'(k));
      assign can_load[k] = !v_q || out_ready[k];

      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= 1'b0;
          d_q <= '0;
          l_q <= 1'b0;
        end else if (load) begin
          v_q <= 1'b1;
          d_q <= in_data;
          l_q <= in_last;
        end else if (out_ready[k]) begin
          v_q <= 1'b0;
        end
      end

      assign out_valid[k]              = v_q;
      assign out_last[k]               = l_q;
      assign out_data[k*WIDTH +: WIDTH] = d_q;
    end else begin : g_none
      assign can_load[k] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else if (accept) begin
      case (state_q)
        IDLE: if (!in_last) begin
          state_q <= LOCKED;
          sel_q   <= in_sel;
        end
        LOCKED: if (in_last) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else if (accept && (int'(eff) >= N_OUT) && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_stream_demux_n.sv
// Bench for stream_demux_n: directed vector table, hand sequences for reset cases,
// and random traffic checked against a queue-based model of the routing rules.
module tb_stream_demux_n;

  localparam int W = 8;
  localparam int N = 5;
  localparam int S = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   in_data;
  logic [S-1:0]   in_sel;
  logic           in_valid;
  logic           in_last;
  logic           in_ready;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_last;
  logic [N-1:0]   out_ready;
  logic           busy;
`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic [15:0]    drop_cnt;
`endif

  stream_demux_n #(.WIDTH(W), .N_OUT(N), .SEL_W(S)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .busy(busy)
`ifdef STREAM_DEMUX_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each channel is a FIFO of beats, routing follows the packet lock rules.
  typedef struct packed { logic [W-1:0] d; logic l; } beat_t;
  beat_t     chq[N][$];
  bit        m_locked = 0;
  int        m_lsel   = 0;
  int        m_drop   = 0;
  // Values captured before the edge, applied to the model after it.
  bit        p_rst, p_acc, p_last;
  int        p_eff, p_sel;
  logic [W-1:0] p_data;
  logic [N-1:0] p_rdy;

  task automatic pre(input bit r, input bit v, input int s, input bit l,
                     input logic [W-1:0] d, input logic [N-1:0] rdy);
    bit er;
    rst = r; in_valid = v; in_sel = S'(s); in_last = l; in_data = d; out_ready = rdy;
    #3;
    p_eff = m_locked ? m_lsel : s;
    er = (p_eff < N) ? (chq[p_eff].size() == 0 || rdy[p_eff]) : 1'b1;
    if (!r) chk("in_ready_model", in_ready, er);
    p_rst = r; p_acc = v && er; p_last = l; p_sel = s; p_data = d; p_rdy = rdy;
  endtask

  task automatic post();
    @(posedge clk); #1;
    if (p_rst) begin
      for (int k = 0; k < N; k++) chq[k].delete();
      m_locked = 0; m_lsel = 0; m_drop = 0;
    end else begin
      for (int k = 0; k < N; k++)
        if (chq[k].size() != 0 && p_rdy[k]) void'(chq[k].pop_front());
      if (p_acc) begin
        if (p_eff < N) chq[p_eff].push_back(beat_t'{d: p_data, l: p_last});
        else if (m_drop < 16'hFFFF) m_drop++;
        if (!m_locked && !p_last) begin m_locked = 1; m_lsel = p_sel; end
        else if (m_locked && p_last) m_locked = 0;
      end
    end
    for (int k = 0; k < N; k++) begin
      chk($sformatf("out_valid[%0d]", k), out_valid[k], chq[k].size() != 0);
      if (chq[k].size() != 0) begin
        chk($sformatf("out_data[%0d]", k), out_data[k*W +: W], chq[k][0].d);
        chk($sformatf("out_last[%0d]", k), out_last[k], chq[k][0].l);
      end
    end
    chk("busy_model", busy, m_locked);
`ifdef STREAM_DEMUX_DROP_CNT_EN
    chk("drop_cnt_model", drop_cnt, m_drop);
`endif
  endtask

  typedef struct packed {
    bit v; logic [S-1:0] sel; bit l; logic [W-1:0] d; logic [N-1:0] rdy;
    bit er; logic [N-1:0] eov; bit eb;
  } tvec_t;
  tvec_t tab[$];

  initial begin
    // Single beats to every channel, full throughput.
    for (int k = 0; k < N; k++)
      tab.push_back(tvec_t'{1, S'(k), 1, W'(8'h10 + k), 5'h1f, 1, N'(1 << k), 0});
    // 3-beat packet locked to channel 2 while in_sel moves to 4.
    tab.push_back(tvec_t'{1, 3'd2, 0, 8'hA1, 5'h1f, 1, 5'b00100, 1});
    tab.push_back(tvec_t'{1, 3'd4, 0, 8'hA2, 5'h1f, 1, 5'b00100, 1});
    tab.push_back(tvec_t'{1, 3'd4, 1, 8'hA3, 5'h1f, 1, 5'b00100, 0});
    tab.push_back(tvec_t'{0, 3'd0, 0, 8'h00, 5'h1f, 1, 5'b00000, 0});
    // Backpressure on channel 1, other channel still flows, then drain+load.
    tab.push_back(tvec_t'{1, 3'd1, 1, 8'h41, 5'b11101, 1, 5'b00010, 0});
    tab.push_back(tvec_t'{1, 3'd1, 1, 8'h42, 5'b11101, 0, 5'b00010, 0});
    tab.push_back(tvec_t'{1, 3'd3, 1, 8'h43, 5'b11101, 1, 5'b01010, 0});
    tab.push_back(tvec_t'{1, 3'd1, 1, 8'h42, 5'b11111, 1, 5'b00010, 0});
    tab.push_back(tvec_t'{0, 3'd0, 0, 8'h00, 5'h1f, 1, 5'b00000, 0});
    // Packet to a non-existent channel is swallowed, then a normal beat.
    tab.push_back(tvec_t'{1, 3'd6, 0, 8'h60, 5'h1f, 1, 5'b00000, 1});
    tab.push_back(tvec_t'{1, 3'd0, 1, 8'h61, 5'h1f, 1, 5'b00000, 0});
    tab.push_back(tvec_t'{1, 3'd0, 1, 8'h70, 5'h1f, 1, 5'b00001, 0});

    // Reset held with traffic present: nothing may come out.
    for (int i = 0; i < 2; i++) begin
      pre(1, 1, 0, 1, 8'hEE, 5'h1f); post();
      chk("rst_out_valid", out_valid, 5'b0);
      chk("rst_busy", busy, 1'b0);
    end
    pre(0, 0, 0, 1, 8'hEE, 5'h1f); post();
    chk("post_rst_out_valid", out_valid, 5'b0);

    foreach (tab[i]) begin
      pre(0, tab[i].v, int'(tab[i].sel), tab[i].l, tab[i].d, tab[i].rdy);
      chk($sformatf("tab%0d_in_ready", i), in_ready, tab[i].er);
      post();
      chk($sformatf("tab%0d_out_valid", i), out_valid, tab[i].eov);
      chk($sformatf("tab%0d_busy", i), busy, tab[i].eb);
    end
    chk("ch0_data_after_drop", out_data[0 +: W], 8'h70);
`ifdef STREAM_DEMUX_DROP_CNT_EN
    chk("drop_cnt_two", drop_cnt, 16'd2);
`endif

    // Reset in the middle of a packet; next beat starts a fresh packet.
    pre(0, 1, 3, 0, 8'h31, 5'h1f); post();
    chk("mid_busy_set", busy, 1'b1);
    chk("mid_ch3_valid", out_valid, 5'b01000);
    pre(1, 1, 3, 0, 8'h32, 5'h1f); post();
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_valid", out_valid, 5'b00000);
    pre(0, 1, 1, 1, 8'h33, 5'h1f); post();
    chk("mid_new_first_valid", out_valid, 5'b00010);
    chk("mid_new_first_data", out_data[1*W +: W], 8'h33);

    // Random traffic, including invalid selects and backpressure.
    for (int i = 0; i < 600; i++) begin
      pre(0, $urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
          $urandom_range(0, 2) == 0, W'($urandom), N'($urandom | $urandom));
      post();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_demux_n.md
Name: stream_demux_n

Overview:
Parametrised 1:N stream demultiplexer with valid/ready handshake and one registered output stage per channel. It is the successor to the combinational 1:4 demux and adds arbitrary width and channel count, backpressure, and packet-locked routing: the select is sampled on a packet's first beat and held until its last beat. It sits between a single producer and N independent consumers.

Parameters:
WIDTH, 8, data bits per beat
N_OUT, 4, number of output channels (2..16, not required to be a power of two)
SEL_W, 2, select width; must satisfy 2**SEL_W >= N_OUT

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
in_data  input  WIDTH  input beat payload
in_sel  input  SEL_W  destination channel; sampled only on a packet's first beat
in_valid  input  1  input beat present
in_last  input  1  input beat ends its packet
in_ready  output  1  block accepts the input beat this cycle
out_data  output  N_OUT*WIDTH  channel k uses bits [k*WIDTH +: WIDTH]
out_valid  output  N_OUT  per-channel beat present
out_last  output  N_OUT  per-channel last flag
out_ready  input  N_OUT  per-channel consumer ready
busy  output  1  high while a packet is mid-flight (state LOCKED)

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: out_valid=0, out_data=0, out_last=0, state=IDLE, latched select=0, busy=0. Reset has priority over all other events. A reset mid-packet discards the packet and any held beats.
- FSM states:
  - IDLE: the effective select is in_sel.
  - LOCKED: the effective select is the latched select, and in_sel is ignored.
- Transitions:
  - IDLE -> LOCKED on an accepted beat with in_last=0; in_sel is latched on that beat.
  - LOCKED -> IDLE on an accepted beat with in_last=1.
  - A single-beat packet (first beat has in_last=1) stays in IDLE.
- Accept: a beat is accepted when in_valid && in_ready.
- Per-channel register (one entry per channel):
  - Empty when out_valid[k]=0.
  - Drains when out_valid[k] && out_ready[k].
- in_ready, with eff = effective select:
  - eff < N_OUT: in_ready = !out_valid[eff] || out_ready[eff]. This is combinational, with no loop through in_valid.
  - eff >= N_OUT: in_ready=1. The beat is accepted and silently dropped, and the FSM still tracks in_last. A packet to an invalid channel is therefore dropped in full.
- Latency: an accepted beat appears on out_*[eff] on the next cycle.
- Simultaneous drain and load on the same channel gives full throughput of 1 beat/cycle per channel with no bubble.
- Non-selected channels keep their held beat stable until drained. out_data[k] and out_last[k] must not change while out_valid[k]=1 && !out_ready[k].
- Ordering: beats leave each channel in arrival order. No ordering is implied across channels.
- Sel changes while in_valid=1 in IDLE are legal. The decision uses the value on the accepting cycle.

Optional Feature:
Macro: STREAM_DEMUX_DROP_CNT_EN.
- Defined:
  - Adds output port drop_cnt (16 bits): a saturating count of dropped beats (eff >= N_OUT).
  - drop_cnt resets to 0 and holds at 16'hFFFF once reached.
- Undefined: the port and counter are absent, and drop behaviour is otherwise identical.

Test Plan:
(Bench parameters: WIDTH=8, N_OUT=5, SEL_W=3.)
1. Reset: hold rst=1 for 2 cycles with in_valid=1 -> all out_valid=0, busy=0, and no beat appears after release until a new accept occurs.
2. Single beats: out_ready=5'b11111; send data 0x10..0x14 with in_sel=0..4, in_last=1, back to back -> each appears on channel k exactly 1 cycle after accept; in_ready stays 1 throughout; busy stays 0.
3. Packet lock: send 3-beat packet A1,A2,A3 to sel=2, with in_sel driven to 4 on beats 2-3 -> all three beats exit on channel 2; busy=1 from the cycle after A1 until the cycle after A3.
4. Backpressure: out_ready[1]=0; send two beats to sel=1 -> first beat is held with stable out_data; in_ready=0 for the second beat; a concurrent beat to sel=3 is still accepted; raising out_ready[1] drains beat 1 and accepts beat 2 in the same cycle.
5. Invalid channel: 2-beat packet to sel=6, then a beat to sel=0 -> no out_valid on any channel for the packet; in_ready=1 throughout; the sel=0 beat is delivered; with the macro defined, drop_cnt=2.
6. Reset mid-packet: assert rst after beat 1 of a 3-beat packet to sel=3 -> busy=0 and out_valid[3]=0; the next beat is treated as a first beat with its own in_sel.
